// File: rtl/seqdet_pkg.sv
// rtl/seqdet_pkg.sv - shared types and constants for the serial pattern detector
package seqdet_pkg;

  typedef enum logic {
    SEQDET_MEALY = 1'b0,
    SEQDET_MOORE = 1'b1
  } seqdet_mode_e;

  localparam int         SEQDET_MAX_LEN = 32;
  localparam logic [3:0] SEQDET_DEF_PAT = 4'b1011;

  // The fill counter must be able to hold SEQ_LEN itself, not just SEQ_LEN-1.
  function automatic int seqdet_fill_w(input int seq_len);
    return $clog2(seq_len + 1);
  endfunction

endpackage

// File: rtl/seqdet_match_counter.sv
// rtl/seqdet_match_counter.sv - saturating match counter
module seqdet_match_counter
  import seqdet_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/param_sequence_detector.sv
// rtl/param_sequence_detector.sv - parametrised serial pattern detector; SEQDET_MATCH_COUNT_EN builds the match counter
module param_sequence_detector
  import seqdet_pkg::*;
#(
  parameter int           SEQ_LEN  = 4,
  parameter               SEQ_INIT = SEQDET_DEF_PAT,
  parameter seqdet_mode_e MODE     = SEQDET_MOORE,
  parameter int           OVERLAP  = 1,
  parameter int           CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in,
  input  logic               in_valid,
  input  logic               pat_load,
  input  logic [SEQ_LEN-1:0] pat_in,
  output logic               out,
  output logic [CNT_W-1:0]   match_count
);

  localparam int                  FILL_W   = seqdet_fill_w(SEQ_LEN);
  localparam logic [FILL_W-1:0]   FILL_MAX = FILL_W'(SEQ_LEN);
  localparam logic [FILL_W-1:0]   FILL_ARM = FILL_W'(SEQ_LEN - 1);
  localparam logic [SEQ_LEN-1:0]  PAT_RST  = SEQ_LEN'(SEQ_INIT);

  if ((SEQ_LEN < 2) || (SEQ_LEN > SEQDET_MAX_LEN) || ($bits(SEQ_INIT) != SEQ_LEN)) begin : g_bad_params
    $error("param_sequence_detector: SEQ_LEN must be 2..32 and SEQ_INIT must be SEQ_LEN bits wide");
  end

  logic [SEQ_LEN-1:0] hist;
  logic [SEQ_LEN-1:0] pat;
  logic [SEQ_LEN-1:0] shifted;
  logic [FILL_W-1:0]  fill;
  logic               match_q;
  logic               accept;
  logic               hit;

  // A bit is dropped while reset or pat_load is high, so it can never complete a match.
  assign accept  = in_valid && !pat_load && !reset;
  assign shifted = {hist[SEQ_LEN-2:0], in};
  assign hit     = accept && (fill >= FILL_ARM) && (shifted == pat);

  always_ff @(posedge clk) begin
    if (reset) begin
      hist    <= '0;
      fill    <= '0;
      pat     <= PAT_RST;
      match_q <= 1'b0;
    end else if (pat_load) begin
      pat     <= pat_in;
      fill    <= '0;
      match_q <= 1'b0;
    end else if (in_valid) begin
      hist    <= shifted;
      match_q <= hit;
      if (hit && (OVERLAP == 0)) begin
        fill <= '0;
      end else if (fill != FILL_MAX) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

  assign out = (MODE == SEQDET_MOORE) ? match_q : hit;

`ifdef SEQDET_MATCH_COUNT_EN
  seqdet_match_counter #(
    .CNT_W (CNT_W)
  ) u_match_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (hit),
    .count (match_count)
  );
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_param_sequence_detector.sv
// tb/tb_param_sequence_detector.sv - scoreboard bench for param_sequence_detector
module tb_param_sequence_detector;
  import seqdet_pkg::*;

`ifdef SEQDET_MATCH_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din = 1'b0;
  logic       in_valid = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;

  logic       out_moore, out_noov, out_mealy, out_sat;
  logic [7:0] cnt_moore, cnt_noov, cnt_mealy;
  logic [1:0] cnt_sat;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  param_sequence_detector u_moore (
    .clk(clk), .reset(reset), .in(din), .in_valid(in_valid), .pat_load(pat_load),
    .pat_in(pat_in), .out(out_moore), .match_count(cnt_moore));

  param_sequence_detector #(.OVERLAP(0)) u_noov (
    .clk(clk), .reset(reset), .in(din), .in_valid(in_valid), .pat_load(pat_load),
    .pat_in(pat_in), .out(out_noov), .match_count(cnt_noov));

  param_sequence_detector #(.MODE(SEQDET_MEALY)) u_mealy (
    .clk(clk), .reset(reset), .in(din), .in_valid(in_valid), .pat_load(pat_load),
    .pat_in(pat_in), .out(out_mealy), .match_count(cnt_mealy));

  param_sequence_detector #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .in(din), .in_valid(in_valid), .pat_load(pat_load),
    .pat_in(pat_in), .out(out_sat), .match_count(cnt_sat));

  typedef struct packed {
    logic       o0;
    logic       o1;
    logic       o3;
    logic [7:0] c0;
    logic [7:0] c1;
    logic [7:0] c2;
    logic [1:0] c3;
  } exp_t;

  exp_t sb[$];

  // Reference model: index 0 moore, 1 no-overlap, 2 mealy, 3 two-bit counter
  logic [3:0] m_hist[4];
  int         m_fill[4];
  logic       m_mq[4];
  int         m_cnt[4];
  logic [3:0] m_pat = 4'b1011;
  logic       m_mealy;
  bit         m_ov[4]   = '{1'b1, 1'b0, 1'b1, 1'b1};
  int         m_cmax[4] = '{255, 255, 255, 3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic b,
                            input logic ld, input logic [3:0] p);
    logic h;
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      h = !r && !ld && v && (m_fill[k] >= 3) && ({m_hist[k][2:0], b} == m_pat);
      if (k == 2) m_mealy = h;
      if (r) begin
        m_hist[k] = 4'b0000;
        m_fill[k] = 0;
        m_mq[k]   = 1'b0;
        m_cnt[k]  = 0;
      end else if (ld) begin
        m_fill[k] = 0;
        m_mq[k]   = 1'b0;
      end else if (v) begin
        m_hist[k] = {m_hist[k][2:0], b};
        m_mq[k]   = h;
        if (h && !m_ov[k]) m_fill[k] = 0;
        else if (m_fill[k] < 4) m_fill[k]++;
        if (h && (m_cnt[k] < m_cmax[k])) m_cnt[k]++;
      end
    end
    if (r) m_pat = 4'b1011;
    else if (ld) m_pat = p;
    e.o0 = m_mq[0];
    e.o1 = m_mq[1];
    e.o3 = m_mq[3];
    e.c0 = CNT_ON ? 8'(m_cnt[0]) : 8'd0;
    e.c1 = CNT_ON ? 8'(m_cnt[1]) : 8'd0;
    e.c2 = CNT_ON ? 8'(m_cnt[2]) : 8'd0;
    e.c3 = CNT_ON ? 2'(m_cnt[3]) : 2'd0;
    sb.push_back(e);
  endtask

  task automatic drive(input logic r, input logic v, input logic b,
                       input logic ld, input logic [3:0] p);
    @(negedge clk);
    reset    = r;
    in_valid = v;
    din      = b;
    pat_load = ld;
    pat_in   = p;
    #1;
    model_step(r, v, b, ld, p);
    chk("mealy_out", {31'd0, out_mealy}, {31'd0, m_mealy});
  endtask

  task automatic bit_in(input logic b);
    drive(1'b0, 1'b1, b, 1'b0, 4'b0000);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("moore_out",  {31'd0, out_moore}, {31'd0, e.o0});
        chk("noov_out",   {31'd0, out_noov},  {31'd0, e.o1});
        chk("sat_out",    {31'd0, out_sat},   {31'd0, e.o3});
        chk("moore_cnt",  {24'd0, cnt_moore}, {24'd0, e.c0});
        chk("noov_cnt",   {24'd0, cnt_noov},  {24'd0, e.c1});
        chk("mealy_cnt",  {24'd0, cnt_mealy}, {24'd0, e.c2});
        chk("sat_cnt",    {30'd0, cnt_sat},   {30'd0, e.c3});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [6:0] s1;
    int saved;
    s1 = 7'b1011011;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    settle();
    chk("reset_moore_out", {31'd0, out_moore}, 32'd0);
    chk("reset_cnt", {24'd0, cnt_moore}, 32'd0);

    for (int i = 6; i >= 0; i--) bit_in(s1[i]);
    idle();
    settle();
    chk("plan_moore_hold", {31'd0, out_moore}, 32'd1);
    chk("plan_moore_cnt2", {24'd0, cnt_moore}, CNT_ON ? 32'd2 : 32'd0);
    chk("plan_noov_cnt1",  {24'd0, cnt_noov},  CNT_ON ? 32'd1 : 32'd0);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    bit_in(1'b1);
    bit_in(1'b0);
    idle();
    idle();
    idle();
    bit_in(1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
    chk("plan_mealy_gap_hit", {31'd0, out_mealy}, 32'd1);
    idle();
    chk("plan_mealy_after", {31'd0, out_mealy}, 32'd0);

    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'b0110);
    bit_in(1'b0);
    bit_in(1'b1);
    bit_in(1'b1);
    bit_in(1'b0);
    settle();
    chk("plan_load_0110_hit", {31'd0, out_moore}, 32'd1);

    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b1011);
    bit_in(1'b1);
    bit_in(1'b0);
    bit_in(1'b1);
    saved = m_cnt[0];
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'b1011);
    settle();
    chk("plan_load_vs_hit_out", {31'd0, out_moore}, 32'd0);
    chk("plan_load_vs_hit_cnt", {24'd0, cnt_moore}, CNT_ON ? 32'(saved) : 32'd0);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    bit_in(1'b1);
    bit_in(1'b0);
    bit_in(1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
    bit_in(1'b1);
    bit_in(1'b0);
    bit_in(1'b1);
    bit_in(1'b1);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    bit_in(1'b1);
    for (int i = 0; i < 5; i++) begin
      bit_in(1'b0);
      bit_in(1'b1);
      bit_in(1'b1);
    end
    settle();
    chk("plan_sat_cnt3",   {30'd0, cnt_sat},   CNT_ON ? 32'd3 : 32'd0);
    chk("plan_moore_cnt5", {24'd0, cnt_moore}, CNT_ON ? 32'd5 : 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic r, v, b, ld;
      logic [3:0] p;
      r  = ($urandom_range(0, 59) == 0);
      ld = ($urandom_range(0, 24) == 0);
      v  = ($urandom_range(0, 3) != 0);
      b  = 1'($urandom_range(0, 1));
      p  = 4'($urandom_range(0, 15));
      drive(r, v, b, ld, p);
    end

    idle();
    idle();
    settle();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_sequence_detector.md
# param_sequence_detector

Parametrised serial bit-pattern detector, successor to the fixed "1011" Moore detector. Pattern length, reset pattern, Mealy/Moore output mode and overlap policy are elaboration-time parameters, and the pattern can be reloaded at run time. The block sits on a single-bit serial input stream and flags each occurrence of the pattern, optionally counting matches.

## Interface
- SEQ_LEN, 4: pattern length in bits, legal range 2..32.
- SEQ_INIT, 4'b1011: pattern loaded at reset, width SEQ_LEN, MSB is the first bit received.
- MODE, SEQDET_MOORE: SEQDET_MOORE (registered output) or SEQDET_MEALY (combinational output).
- OVERLAP, 1: 1 = overlapping matches allowed; 0 = history is cleared after each match.
- CNT_W, 8: match counter width.

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in  in  1  serial data bit.
- in_valid  in  1  in is sampled only when high.
- pat_load  in  1  load pat_in as the new pattern.
- pat_in  in  SEQ_LEN  new pattern, MSB first.
- out  out  1  match indication.
- match_count  out  CNT_W  saturating count of matches.

## Operation
- State: hist[SEQ_LEN-1:0] shift register (newest bit in LSB), fill counter 0..SEQ_LEN (saturating), pattern register pat, Moore flag match_q, counter.
- Hit condition: in_valid && fill >= SEQ_LEN-1 && {hist[SEQ_LEN-2:0], in} == pat.
- Accepted bit (in_valid=1, pat_load=0): hist shifts left taking in; fill increments, saturating at SEQ_LEN.
- On a hit with OVERLAP=0: fill is cleared to 0 instead of incremented. hist still shifts.
- in_valid=0: hist, fill and match_q hold.
- pat_load=1: pat <= pat_in, fill <= 0, match_q <= 0. Takes priority over in_valid, so the bit presented in that cycle is dropped and never counted.
- Mealy mode: out = hit, combinational, same cycle as the completing bit.
- Moore mode: match_q <= hit on every accepted bit. out = match_q. out stays high until the next accepted bit or pat_load.
- Counter increments by 1 per hit and saturates at all-ones; it does not wrap.
- Reset values: hist=0, fill=0, pat=SEQ_INIT, match_q=0, out=0, match_count=0.

## Timing
- Mealy latency 0 cycles: out is valid in the same cycle as the completing bit. Moore latency 1 cycle: out rises after the edge that samples that bit.
- match_count reflects a hit one cycle after the completing bit, in both modes.
- Reset asserted mid-stream: at the next edge all state returns to reset values, and a partial match is discarded. A bit presented with reset high is ignored.
- pat_load in the same cycle as a hit: no hit is registered and the counter does not increment.
- The first SEQ_LEN-1 accepted bits after reset or load can never produce a hit.

## Configuration
- SEQDET_MATCH_COUNT_EN
  - Defined: the counter sub-module is instantiated and match_count is live.
  - Undefined: no counter logic is built and match_count is tied to 0. out behaviour is identical in both cases.

## Structure
- seqdet_pkg holds:
  - the mode typedef enum {SEQDET_MEALY, SEQDET_MOORE};
  - constants SEQDET_MAX_LEN=32 and SEQDET_DEF_PAT=4'b1011;
  - the fill-counter width function clog2(SEQ_LEN+1).
- One sub-module, seqdet_match_counter: saturating CNT_W counter with inputs clk, reset, inc.
- Parameter legality (SEQ_LEN range, SEQ_INIT width) is checked with an elaboration-time assertion.

## Test plan
- Default parameters (Moore, OVERLAP=1), reset held 2 cycles, then 1,0,1,1,0,1,1 with in_valid=1 -> out high in the cycle after bits 4 and 7; match_count=2.
- Same stream with OVERLAP=0 -> single pulse after bit 4; match_count=1.
- MODE=SEQDET_MEALY with stream 1,0,1,1 -> out high combinationally during bit 4, low before and after; in_valid gap of 3 cycles between bits 2 and 3 -> still detected.
- pat_load with pat_in=4'b0110, then stream 0,1,1,0 -> match; with pat_load concurrent with a completing 1011 bit -> no match, match_count unchanged.
- CNT_W=2 with 5 matches -> match_count saturates at 3. Without SEQDET_MATCH_COUNT_EN -> match_count stays 0.
- Reset asserted after 1,0,1, then stream 1 -> no match; a following 0,1,1 also gives no match until a full 1011 is seen.
